// File: rtl/pll_lock_sequencer.sv
// PLLVR bring-up sequencer: pulses the PLL reset, qualifies LOCK and holds the
// downstream system reset until lock is stable; retries on timeout and accepts divider changes.

module pll_lock_sequencer #(
    parameter int         RESET_CYCLES = 16,
    parameter int         LOCK_TIMEOUT = 65535,
    parameter int         LOCK_STABLE  = 1024,
    parameter int         MAX_RETRY    = 3,
    parameter logic [5:0] DEF_IDSEL    = 6'd0,
    parameter logic [5:0] DEF_FBDSEL   = 6'd0,
    parameter logic [5:0] DEF_ODSEL    = 6'd0
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       cfg_req,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       cfg_ack,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       busy,
    output logic       fail,
    output logic [1:0] retry_cnt
);

    localparam int PH_MAX = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int ST_W   = $clog2(LOCK_STABLE + 1);

    localparam logic [PH_W-1:0] RESET_LAST   = PH_W'(RESET_CYCLES - 1);
    localparam logic [PH_W-1:0] TIMEOUT_LAST = PH_W'(LOCK_TIMEOUT - 1);
    localparam logic [ST_W-1:0] STABLE_LAST  = ST_W'(LOCK_STABLE - 1);

    typedef enum logic [2:0] {
        S_RESET_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t          state, state_next;
    logic [PH_W-1:0] ph_cnt, ph_cnt_next;
    logic [ST_W-1:0] st_cnt, st_cnt_next;
    logic [1:0]      retry_next;
    logic [1:0]      retry_inc;
    logic            lk_meta, lk_s;
    logic            accept;

    assign retry_inc = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;

    assign locked = (state == S_RUN);
    assign busy   = (state == S_RESET_HOLD) || (state == S_WAIT_LOCK) || (state == S_STABLE);
    assign fail   = (state == S_FAULT);

    // ph_cnt times both the reset pulse and the lock timeout; st_cnt counts consecutive lk_s cycles.
    always_comb begin
        state_next  = state;
        ph_cnt_next = ph_cnt;
        st_cnt_next = st_cnt;
        retry_next  = retry_cnt;
        accept      = 1'b0;

        case (state)
            S_RESET_HOLD: begin
                if (ph_cnt == RESET_LAST) begin
                    state_next  = S_WAIT_LOCK;
                    ph_cnt_next = '0;
                end else begin
                    ph_cnt_next = ph_cnt + PH_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lk_s) begin
                    ph_cnt_next = '0;
                    if (LOCK_STABLE <= 1) begin
                        state_next = S_RUN;
                        retry_next = '0;
                    end else begin
                        state_next  = S_STABLE;
                        st_cnt_next = ST_W'(1);
                    end
                end else if (ph_cnt == TIMEOUT_LAST) begin
                    ph_cnt_next = '0;
                    retry_next  = retry_inc;
                    if (int'(retry_inc) >= MAX_RETRY) begin
                        state_next = S_FAULT;
                    end else begin
                        state_next = S_RESET_HOLD;
                    end
                end else begin
                    ph_cnt_next = ph_cnt + PH_W'(1);
                end
            end
            S_STABLE: begin
                if (!lk_s) begin
                    state_next  = S_WAIT_LOCK;
                    ph_cnt_next = '0;
                    st_cnt_next = '0;
                end else if (st_cnt == STABLE_LAST) begin
                    state_next  = S_RUN;
                    st_cnt_next = '0;
                    retry_next  = '0;
                end else begin
                    st_cnt_next = st_cnt + ST_W'(1);
                end
            end
            S_RUN: begin
                if (cfg_req) begin
                    accept = 1'b1;
                end else if (!lk_s) begin
                    state_next  = S_RESET_HOLD;
                    ph_cnt_next = '0;
                end
            end
            S_FAULT: begin
                if (cfg_req) begin
                    accept = 1'b1;
                end
            end
            default: begin
                state_next  = S_RESET_HOLD;
                ph_cnt_next = '0;
                st_cnt_next = '0;
            end
        endcase

        // A reconfiguration always restarts the whole sequence from a fresh PLL reset.
        if (accept) begin
            state_next  = S_RESET_HOLD;
            ph_cnt_next = '0;
            st_cnt_next = '0;
            retry_next  = '0;
        end
    end

    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            state      <= S_RESET_HOLD;
            ph_cnt     <= '0;
            st_cnt     <= '0;
            retry_cnt  <= '0;
            lk_meta    <= 1'b0;
            lk_s       <= 1'b0;
            pll_reset  <= 1'b1;
            sys_rst_n  <= 1'b0;
            cfg_ack    <= 1'b0;
            pll_idsel  <= DEF_IDSEL;
            pll_fbdsel <= DEF_FBDSEL;
            pll_odsel  <= DEF_ODSEL;
        end else begin
            lk_meta   <= pll_lock;
            lk_s      <= lk_meta;
            state     <= state_next;
            ph_cnt    <= ph_cnt_next;
            st_cnt    <= st_cnt_next;
            retry_cnt <= retry_next;
            pll_reset <= (state_next == S_RESET_HOLD) || (state_next == S_FAULT);
            sys_rst_n <= (state_next == S_RUN);
            cfg_ack   <= accept;
            if (accept) begin
                pll_idsel  <= cfg_idsel;
                pll_fbdsel <= cfg_fbdsel;
                pll_odsel  <= cfg_odsel;
            end
        end
    end

endmodule
